// File: rtl/bram_row_rd_pkg.sv
// Shared types and default constants for the BRAM row reader.
// The FSM encoding and pixel width are used by the top and its output FIFO.
package bram_row_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int DEF_ROW_PX    = 640;
    localparam int DEF_LAST_ADDR = 'h1400;
    localparam int PX_W          = 16;

    // FIFO entry layout: {sol, eol, pixel}
    localparam int FIFO_W = PX_W + 2;

    // Bits needed to hold a value in 0..max_val inclusive, never less than 1.
    function automatic int bits_for(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bram_row_rd_fifo.sv
// Small synchronous skid FIFO holding tagged grey pixels between BRAM and sink.
// The head entry is visible combinationally; a write is never bypassed to the output.
module px_fifo
    import bram_row_rd_pkg::*;
#(
    parameter int WIDTH = FIFO_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = bits_for(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_DEPTH);
    assign count   = count_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bram_row_rd.sv
// Drains one row at a time from the converter's BRAM ring buffer and streams it
// out as valid/ready grey pixels tagged with start/end-of-line markers.
module bram_row_rd
    import bram_row_rd_pkg::*;
#(
    parameter int ROW_PX     = DEF_ROW_PX,
    parameter int LAST_ADDR  = DEF_LAST_ADDR,
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wnd_in_bram,
    input  logic [31:0]       bram_to_rd_data,
    output logic              rd_to_bram_en,
    output logic [ADDR_W-1:0] rd_to_bram_addr,
    output logic [PX_W-1:0]   px_out_data,
    output logic              px_out_valid,
    input  logic              px_out_ready,
    output logic              px_out_sol,
    output logic              px_out_eol,
    output logic              pixel_ack,
    output logic [15:0]       row_cnt,
    output logic              busy
);

    localparam int ISS_W = bits_for(ROW_PX - 1);
    localparam int CNT_W = bits_for(FIFO_DEPTH);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(LAST_ADDR);
    localparam logic [ISS_W-1:0]  ISS_LAST = ISS_W'(ROW_PX - 1);
    localparam logic [OCC_W-1:0]  OCC_MAX  = OCC_W'(FIFO_DEPTH);

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   rd_addr_reg;
    logic [ISS_W-1:0]    issue_cnt_reg;
    logic                inflight_reg;
    logic                sol_tag_reg;
    logic                eol_tag_reg;
    logic [15:0]         row_cnt_reg;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                unused_fifo_full;
    logic [FIFO_W-1:0]   fifo_head;
    logic [FIFO_W-1:0]   fifo_wr_data;
    logic [OCC_W-1:0]    occupancy;
    logic                rd_en;
    logic                last_issue;
    logic                pop;
    logic                eol_hs;
    logic                unused_hi;

    // Upper half of the BRAM word carries nothing for this reader.
    assign unused_hi = ^bram_to_rd_data[31:PX_W];

    // A read is only issued if its data is guaranteed a FIFO slot when it lands.
    assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
    assign rd_en      = (state_reg == READ) && (occupancy < OCC_MAX);
    assign last_issue = rd_en && (issue_cnt_reg == ISS_LAST);

    assign rd_to_bram_en   = rd_en;
    assign rd_to_bram_addr = rd_addr_reg;

    // Head fields are masked while empty so the stream reads as zero when idle.
    assign px_out_valid = !fifo_empty;
    assign px_out_data  = fifo_empty ? '0 : fifo_head[PX_W-1:0];
    assign px_out_sol   = !fifo_empty && fifo_head[PX_W+1];
    assign px_out_eol   = !fifo_empty && fifo_head[PX_W];
    assign pop          = px_out_valid && px_out_ready;
    assign eol_hs       = pop && px_out_eol;
    assign row_cnt      = row_cnt_reg;

    assign fifo_wr_data = {sol_tag_reg, eol_tag_reg, bram_to_rd_data[PX_W-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pixel_ack  = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (wnd_in_bram) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (eol_hs) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                pixel_ack  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ring address survives row boundaries; only reset brings it back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_reg <= '0;
        end else if (rd_en) begin
            rd_addr_reg <= (rd_addr_reg == LAST_A) ? '0 : rd_addr_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= '0;
        end else if (state_reg == ACK) begin
            issue_cnt_reg <= '0;
        end else if (rd_en && !last_issue) begin
            issue_cnt_reg <= issue_cnt_reg + ISS_W'(1);
        end
    end

    // Tags travel with the read so they line up with the returning BRAM word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            sol_tag_reg  <= 1'b0;
            eol_tag_reg  <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
            sol_tag_reg  <= rd_en && (issue_cnt_reg == '0);
            eol_tag_reg  <= last_issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_reg <= '0;
        end else if (state_reg == ACK) begin
            row_cnt_reg <= row_cnt_reg + 16'd1;
        end
    end

    px_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_reg),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (unused_fifo_full)
    );

endmodule

// File: tb/tb_bram_row_rd.sv
// Directed bench for bram_row_rd: a BRAM model returns the address as data and a
// scoreboard queue holds the pixel stream expected from the ring-address model.
module tb_bram_row_rd;

    localparam int ROW_PX    = 640;
    localparam int LAST_ADDR = 'h1400;

    logic        clk;
    logic        rst_n = 1'b1;
    logic        wnd_in_bram = 1'b0;
    logic [31:0] bram_to_rd_data = '0;
    logic        rd_to_bram_en;
    logic [31:0] rd_to_bram_addr;
    logic [15:0] px_out_data;
    logic        px_out_valid;
    logic        px_out_ready;
    logic        px_out_sol;
    logic        px_out_eol;
    logic        pixel_ack;
    logic [15:0] row_cnt;
    logic        busy;

    int total = 0;
    int bad = 0;
    int model_addr = 0;
    int ack_count = 0;
    int hs_in_row = 0;
    int edges;
    bit rand_ready = 1'b0;
    bit expect_ack = 1'b0;
    bit prev_stall = 1'b0;
    logic [18:0] prev_word;
    logic [15:0] first_px = '0;
    logic [15:0] second_px = '0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_word;

    bram_row_rd dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wnd_in_bram     (wnd_in_bram),
        .bram_to_rd_data (bram_to_rd_data),
        .rd_to_bram_en   (rd_to_bram_en),
        .rd_to_bram_addr (rd_to_bram_addr),
        .px_out_data     (px_out_data),
        .px_out_valid    (px_out_valid),
        .px_out_ready    (px_out_ready),
        .px_out_sol      (px_out_sol),
        .px_out_eol      (px_out_eol),
        .pixel_ack       (pixel_ack),
        .row_cnt         (row_cnt),
        .busy            (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // BRAM model: one-cycle read latency, junk in the upper half.
    always @(posedge clk) begin
        if (rd_to_bram_en) begin
            bram_to_rd_data <= {~rd_to_bram_addr[15:0], rd_to_bram_addr[15:0]};
        end
    end

    initial begin
        px_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            px_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_row();
        for (int i = 0; i < ROW_PX; i++) begin
            exp_q.push_back({(i == 0), (i == ROW_PX - 1), 16'(model_addr)});
            model_addr = (model_addr == LAST_ADDR) ? 0 : model_addr + 1;
        end
    endtask

    task automatic start_row();
        push_row();
        @(posedge clk);
        #1 wnd_in_bram = 1'b1;
        @(posedge clk);
        #1 wnd_in_bram = 1'b0;
    endtask

    task automatic wait_acks(input int target, input int budget);
        int n = 0;
        while (ack_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait", 32'(ack_count >= target), 1);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_in_row < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("hs_wait", 32'(hs_in_row >= target), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        model_addr = 0;
        ack_count = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: scoreboard pops, ack timing, stall stability, FIFO bound.
    always @(negedge clk) begin
        if (!rst_n) begin
            expect_ack = 1'b0;
            prev_stall = 1'b0;
            hs_in_row = 0;
        end else begin
            check("pixel_ack", pixel_ack, expect_ack);
            if (pixel_ack) ack_count++;
            expect_ack = 1'b0;
            if (prev_stall) begin
                check("stall_hold", {px_out_valid, px_out_sol, px_out_eol, px_out_data}, prev_word);
            end
            check("fifo_bound", 32'(dut.fifo_count <= 4), 1);
            if (px_out_valid && px_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_px", {px_out_sol, px_out_eol, px_out_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("pixel", {px_out_sol, px_out_eol, px_out_data}, exp_word);
                end
                if (px_out_sol) begin
                    hs_in_row = 0;
                    first_px = px_out_data;
                end
                if (hs_in_row == 1) second_px = px_out_data;
                hs_in_row++;
                if (px_out_eol) begin
                    expect_ack = 1'b1;
                    hs_in_row = 0;
                end
            end
            prev_stall = px_out_valid && !px_out_ready;
            prev_word = {px_out_valid, px_out_sol, px_out_eol, px_out_data};
        end
    end

    initial begin
        // Reset: wnd pulses while in reset must not start reads.
        #1 rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 wnd_in_bram = ~wnd_in_bram;
            check("rst_rd_en", rd_to_bram_en, 0);
        end
        wnd_in_bram = 1'b0;
        check("rst_addr", rd_to_bram_addr, 0);
        check("rst_valid", px_out_valid, 0);
        check("rst_data", px_out_data, 0);
        check("rst_sol", px_out_sol, 0);
        check("rst_eol", px_out_eol, 0);
        check("rst_ack", pixel_ack, 0);
        check("rst_row_cnt", row_cnt, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single row with first-pixel latency.
        push_row();
        @(posedge clk);
        #1 wnd_in_bram = 1'b1;
        @(posedge clk);
        #1 wnd_in_bram = 1'b0;
        check("lat_rd_en", rd_to_bram_en, 1);
        check("lat_first_addr", rd_to_bram_addr, 0);
        check("lat_valid_early", px_out_valid, 0);
        edges = 1;
        while (!px_out_valid && edges < 10) begin
            @(posedge clk);
            #1 edges++;
        end
        check("lat_first_valid", edges, 3);
        wait_acks(1, 1000);
        @(negedge clk);
        check("row1_row_cnt", row_cnt, 1);
        check("row1_left", exp_q.size(), 0);
        check("row1_busy", busy, 0);

        // Backpressure: same 640-pixel sequence from a fresh ring address.
        do_reset();
        rand_ready = 1'b1;
        start_row();
        wait_acks(1, 4000);
        rand_ready = 1'b0;
        @(negedge clk);
        check("bp_row_cnt", row_cnt, 1);
        check("bp_left", exp_q.size(), 0);

        // Nine rows back-to-back across the ring wrap.
        do_reset();
        for (int r = 0; r < 9; r++) push_row();
        @(posedge clk);
        #1 wnd_in_bram = 1'b1;
        edges = 0;
        while (pixel_ack !== 1'b1 && edges < 1000) begin
            @(negedge clk);
            edges++;
        end
        @(negedge clk);
        check("gap_idle", rd_to_bram_en, 0);
        @(negedge clk);
        check("gap_read", rd_to_bram_en, 1);
        wait_acks(8, 7000);
        edges = 0;
        while (rd_to_bram_en !== 1'b1 && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        wnd_in_bram = 1'b0;
        wait_acks(9, 1000);
        @(negedge clk);
        check("wrap_row_cnt", row_cnt, 9);
        check("wrap_acks", ack_count, 9);
        check("wrap_px0", first_px, 'h1400);
        check("wrap_px1", second_px, 0);
        check("wrap_left", exp_q.size(), 0);

        // Async reset mid-row: outputs drop between clock edges.
        start_row();
        wait_hs(300, 1000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", px_out_valid, 0);
        check("arst_rd_en", rd_to_bram_en, 0);
        check("arst_addr", rd_to_bram_addr, 0);
        check("arst_data", px_out_data, 0);
        check("arst_sol", px_out_sol, 0);
        check("arst_eol", px_out_eol, 0);
        check("arst_row_cnt", row_cnt, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        model_addr = 0;
        ack_count = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_row();
        wait_acks(1, 1000);
        check("arst_restart_px0", first_px, 0);
        check("arst_restart_left", exp_q.size(), 0);

        // Window drops mid-row: row completes, then reader stays idle.
        push_row();
        @(posedge clk);
        #1 wnd_in_bram = 1'b1;
        wait_hs(100, 1000);
        wnd_in_bram = 1'b0;
        wait_acks(2, 1000);
        repeat (2) @(posedge clk);
        check("drop_left", exp_q.size(), 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("drop_idle", {busy, rd_to_bram_en}, 0);
        end
        start_row();
        wait_acks(3, 1000);
        @(negedge clk);
        check("drop_row_cnt", row_cnt, 3);
        check("drop_final_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_row_rd.md
# bram_row_rd

Streaming row reader that sits directly downstream of the greyscale pixel converter. It drains the converter's BRAM ring buffer one 640-pixel row at a time once the converter flags a full window (`wnd_in_bram`). It presents the grey pixels as a valid/ready stream with start/end-of-line markers, and pulses `pixel_ack` once per delivered row so the converter can fetch the next row over AXI.

## Interface
Parameters:
- `ROW_PX`, 640: pixels per row; also the number of BRAM reads per row.
- `LAST_ADDR`, 'h1400: highest ring address; the address after `LAST_ADDR` is 0. Matches the converter's write wrap.
- `ADDR_W`, 32: BRAM address width.
- `FIFO_DEPTH`, 4: output skid FIFO depth; must be ≥2.

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wnd_in_bram` in 1: converter flag; a full window is resident in BRAM.
- `bram_to_rd_data` in 32: BRAM read data; grey value in [15:0]; valid 1 cycle after the read enable.
- `rd_to_bram_en` out 1: BRAM read enable.
- `rd_to_bram_addr` out ADDR_W: BRAM read address.
- `px_out_data` out 16: grey pixel.
- `px_out_valid` out 1: pixel valid.
- `px_out_ready` in 1: sink ready.
- `px_out_sol` out 1: start of line, high with pixel 0 of a row.
- `px_out_eol` out 1: end of line, high with pixel ROW_PX-1.
- `pixel_ack` out 1: one-cycle pulse per completed row; feeds the converter's `pixel_ack`.
- `row_cnt` out 16: rows delivered since reset; wraps at 16 bits.
- `busy` out 1: high in any state except IDLE.

## Operation
- FSM states are IDLE, READ, DRAIN, ACK.
  - IDLE → READ when `wnd_in_bram` = 1.
  - READ → DRAIN after the ROW_PX-th read is issued.
  - DRAIN → ACK on the handshake (`valid & ready`) of the pixel with eol set.
  - ACK → IDLE unconditionally.
- `wnd_in_bram` is sampled only in IDLE. If it deasserts mid-row, the current row still completes.
- Read issue: `rd_to_bram_en = (state==READ) & (fifo_count + inflight < FIFO_DEPTH)`, combinational.
  - `inflight` is a 1-bit register equal to last cycle's `rd_to_bram_en`.
  - The FIFO never overflows.
- `rd_addr` register: increments on each issued read; when equal to `LAST_ADDR` it goes to 0 instead. It persists across rows.
- Read-issue counter `issue_cnt` runs 0..ROW_PX-1.
  - sol is tagged when `issue_cnt == 0`; eol when `issue_cnt == ROW_PX-1`.
  - Both tags are pipelined one cycle alongside the read.
- FIFO write: the cycle after a read enable, write `{sol, eol, bram_to_rd_data[15:0]}`.
- `px_out_*` come from the FIFO head; `px_out_valid` = FIFO not empty.
- In ACK: `pixel_ack` = 1, `row_cnt` increments, and `issue_cnt` clears.
- Async reset clears everything mid-operation: state to IDLE, `rd_addr` to 0, FIFO emptied, `inflight` to 0. Reset takes effect immediately, without waiting for `clk`.

## Timing
- Reset values: `rd_to_bram_en` 0, `rd_to_bram_addr` 0, `px_out_valid` 0, `px_out_data` 0, `px_out_sol` 0, `px_out_eol` 0, `pixel_ack` 0, `row_cnt` 0, `busy` 0.
- First-pixel latency:
  - `wnd_in_bram` is sampled high at edge k.
  - `rd_to_bram_en` is high in cycle k+1.
  - BRAM data arrives in cycle k+2.
  - `px_out_valid` is high in cycle k+3.
- Throughput: with `px_out_ready` held high, one pixel per cycle sustained. A row ends 2 cycles after its last read issue.
- `pixel_ack` is high exactly the one cycle after the eol handshake edge. With `wnd_in_bram` still high, the next row's first read issues 2 cycles after `pixel_ack`.
- Backpressure: while `px_out_ready` = 0, `px_out_data`, `px_out_sol` and `px_out_eol` are held stable. Reads stop once `fifo_count + inflight` reaches FIFO_DEPTH.
- Data simultaneously written to an empty FIFO and popped is not allowed to bypass: write-to-valid latency is always 1 cycle.

## Structure
- Package `bram_row_rd_pkg`:
  - state enum (IDLE/READ/DRAIN/ACK);
  - default constants ROW_PX=640, LAST_ADDR='h1400, PX_W=16.
- Sub-module `px_fifo`:
  - synchronous FIFO with async active-low clear;
  - width PX_W+2, depth FIFO_DEPTH;
  - outputs `count`, `empty`, `full`.

## Test plan
- Reset: with `rst_n` = 0, all outputs are at their reset values and `rd_to_bram_addr` = 0. Pulsing `wnd_in_bram` during reset produces no reads.
- Single row: BRAM model returns `addr[15:0]`, `wnd_in_bram` rises at edge k, `ready` = 1.
  - `px_out_valid` first high at k+3.
  - Data runs 0..639 consecutively, sol on 0 and eol on 639.
  - One `pixel_ack` pulse follows, then `row_cnt` = 1.
- Backpressure: `px_out_ready` random at 50%.
  - The 640-pixel sequence is identical to the single-row case.
  - `fifo_count` never exceeds 4, and data is stable while `ready` = 0.
- Wrap: run 9 rows back-to-back.
  - Row 8 pixel 0 is read from 'h1400 and pixel 1 from address 0.
  - `row_cnt` = 9 with 9 `pixel_ack` pulses.
- Async reset at the 300th handshake of a row: all outputs drop immediately without a `clk` edge. After release, the next row starts at address 0 with sol.
- Window drop: `wnd_in_bram` deasserted at pixel 100.
  - The row still delivers 640 pixels and one `pixel_ack`.
  - The FSM then holds IDLE with no reads until `wnd_in_bram` rises again.
